// File: rtl/tilelink_txn_monitor.sv
// Passive TileLink inner-port transaction monitor.
// Tracks every acquire through its grant beats and the following finish, keyed by
// client_xact_id, and reports saturating event counts, outstanding depth, pending finishes,
// worst-case acquire->grant latency and sticky protocol-error flags.
// Optional checking: define TL_TXN_MON_ASSERT_EN to turn each error-flag set into a $error
// (and to flag a non-empty tracker table at the end of simulation).
module tilelink_txn_monitor #(
  parameter int unsigned XACT_ID_W = 4,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned BEAT_W    = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LAT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 acquire_valid_i,
  input  logic                 acquire_ready_i,
  input  logic [XACT_ID_W-1:0] acquire_client_xact_id_i,
  input  logic [BEAT_W-1:0]    acquire_addr_beat_i,
  input  logic                 grant_valid_i,
  input  logic                 grant_ready_i,
  input  logic [XACT_ID_W-1:0] grant_client_xact_id_i,
  input  logic [BEAT_W-1:0]    grant_addr_beat_i,
  input  logic                 grant_has_data_i,
  input  logic                 grant_needs_finish_i,
  input  logic                 finish_valid_i,
  input  logic                 finish_ready_i,
  output logic [CNT_W-1:0]     acq_count_o,
  output logic [CNT_W-1:0]     grant_count_o,
  output logic [CNT_W-1:0]     finish_count_o,
  output logic [XACT_ID_W:0]   outstanding_o,
  output logic [XACT_ID_W:0]   pending_finish_o,
  output logic [LAT_W-1:0]     max_latency_o,
  output logic [2:0]           err_o
);

  localparam int unsigned Entries = 2 ** XACT_ID_W;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StWaitGrant, StInGrant} entry_state_e;

  entry_state_e         state_q [Entries];
  entry_state_e         state_d [Entries];
  logic [LAT_W-1:0]     lat_q   [Entries];
  logic [LAT_W-1:0]     lat_d   [Entries];

  logic [CNT_W-1:0]     acq_cnt_q, acq_cnt_d;
  logic [CNT_W-1:0]     grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]     fin_cnt_q, fin_cnt_d;
  logic [XACT_ID_W:0]   outstanding_q, outstanding_d;
  logic [XACT_ID_W:0]   pending_q, pending_d;
  logic [LAT_W-1:0]     max_lat_q, max_lat_d;
  logic [2:0]           err_q, err_d;

  logic                 acq_fire, grant_fire, fin_fire;
  logic                 grant_close, grant_orphan, dup_acq, fin_orphan, pend_inc;
  logic [XACT_ID_W-1:0] a_idx, g_idx;
  logic [LAT_W-1:0]     close_lat;

  // Next-state for the tracker table, counters and sticky error flags.
  always_comb begin
    acq_fire   = acquire_valid_i & acquire_ready_i & (acquire_addr_beat_i == '0);
    grant_fire = grant_valid_i & grant_ready_i;
    fin_fire   = finish_valid_i & finish_ready_i;
    a_idx      = acquire_client_xact_id_i;
    g_idx      = grant_client_xact_id_i;

    // Busy entries age by one cycle, saturating at all-ones.
    for (int i = 0; i < Entries; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] != StIdle && lat_q[i] != '1) begin
        lat_d[i] = lat_q[i] + LAT_W'(1);
      end else begin
        lat_d[i] = lat_q[i];
      end
    end

    grant_close  = 1'b0;
    grant_orphan = 1'b0;
    // Latency reported on close counts the closing cycle itself.
    close_lat    = (lat_q[g_idx] == '1) ? lat_q[g_idx] : lat_q[g_idx] + LAT_W'(1);

    if (grant_fire) begin
      case (state_q[g_idx])
        StIdle:      grant_orphan = 1'b1;
        StWaitGrant: begin
          if (!grant_has_data_i || grant_addr_beat_i == LastBeat) begin
            grant_close = 1'b1;
          end else begin
            state_d[g_idx] = StInGrant;
          end
        end
        StInGrant:   grant_close = (grant_addr_beat_i == LastBeat);
        default:     grant_orphan = 1'b0;
      endcase
    end
    if (grant_close) begin
      state_d[g_idx] = StIdle;
    end

    // A grant closing the same id this cycle frees the entry before the acquire reopens it.
    dup_acq = acq_fire && (state_q[a_idx] != StIdle) && !(grant_close && (g_idx == a_idx));
    if (acq_fire) begin
      state_d[a_idx] = StWaitGrant;
      lat_d[a_idx]   = '0;
    end

    acq_cnt_d = acq_cnt_q;
    if (acq_fire && acq_cnt_q != '1) begin
      acq_cnt_d = acq_cnt_q + CNT_W'(1);
    end
    grant_cnt_d = grant_cnt_q;
    if (grant_close && grant_cnt_q != '1) begin
      grant_cnt_d = grant_cnt_q + CNT_W'(1);
    end
    fin_cnt_d = fin_cnt_q;
    if (fin_fire && fin_cnt_q != '1) begin
      fin_cnt_d = fin_cnt_q + CNT_W'(1);
    end

    max_lat_d = max_lat_q;
    if (grant_close && close_lat > max_lat_q) begin
      max_lat_d = close_lat;
    end

    // A finish in the same cycle as a finish-requiring close cancels it out.
    pend_inc   = grant_close & grant_needs_finish_i;
    fin_orphan = fin_fire & (pending_q == '0) & ~pend_inc;
    pending_d  = pending_q;
    if (pend_inc && !fin_fire && pending_q != '1) begin
      pending_d = pending_q + (XACT_ID_W + 1)'(1);
    end else if (fin_fire && !pend_inc && pending_q != '0) begin
      pending_d = pending_q - (XACT_ID_W + 1)'(1);
    end

    outstanding_d = '0;
    for (int i = 0; i < Entries; i++) begin
      if (state_d[i] != StIdle) begin
        outstanding_d = outstanding_d + (XACT_ID_W + 1)'(1);
      end
    end

    err_d = err_q | {fin_orphan, grant_orphan, dup_acq};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < Entries; i++) begin
        state_q[i] <= StIdle;
        lat_q[i]   <= '0;
      end
      acq_cnt_q     <= '0;
      grant_cnt_q   <= '0;
      fin_cnt_q     <= '0;
      outstanding_q <= '0;
      pending_q     <= '0;
      max_lat_q     <= '0;
      err_q         <= '0;
    end else begin
      for (int i = 0; i < Entries; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
      acq_cnt_q     <= acq_cnt_d;
      grant_cnt_q   <= grant_cnt_d;
      fin_cnt_q     <= fin_cnt_d;
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
      max_lat_q     <= max_lat_d;
      err_q         <= err_d;
    end
  end

  assign acq_count_o      = acq_cnt_q;
  assign grant_count_o    = grant_cnt_q;
  assign finish_count_o   = fin_cnt_q;
  assign outstanding_o    = outstanding_q;
  assign pending_finish_o = pending_q;
  assign max_latency_o    = max_lat_q;
  assign err_o            = err_q;

`ifdef TL_TXN_MON_ASSERT_EN
  logic [31:0] cycle_q;

  // Free-running cycle stamp for error messages.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Report every protocol violation as it is flagged.
  always_ff @(posedge clk_i) begin
    if (reset_ni) begin
      if (dup_acq) begin
        $error("tl_txn_mon: acquire on busy id %0d at cycle %0d", a_idx, cycle_q);
      end
      if (grant_orphan) begin
        $error("tl_txn_mon: grant on idle id %0d at cycle %0d", g_idx, cycle_q);
      end
      if (fin_orphan) begin
        $error("tl_txn_mon: finish with none pending (id n/a) at cycle %0d", cycle_q);
      end
    end
  end

  final begin
    if (outstanding_q != '0) begin
      $error("tl_txn_mon: %0d transactions outstanding at end of simulation", outstanding_q);
    end
  end
`endif

endmodule

// File: tb/tb_tilelink_txn_monitor.sv
// Scoreboard bench for tilelink_txn_monitor: the driver feeds directed and random traffic,
// a transaction-level model predicts the registered outputs and queues them, and a monitor
// compares each prediction against the DUT one clock later.
module tb_tilelink_txn_monitor;

  localparam int IdW = 4;
  localparam int Beats = 4;
  localparam int LatW = 16;
  localparam longint LatMax = (64'sd1 <<< LatW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       av = 1'b0, ar = 1'b1, gv = 1'b0, gr = 1'b1, ghd = 1'b0, gnf = 1'b0;
  logic       fv = 1'b0, fr = 1'b1;
  logic [3:0] aid = '0, gid = '0;
  logic [1:0] abeat = '0, gbeat = '0;

  logic [31:0] acq_count, grant_count, finish_count;
  logic [4:0]  outstanding, pending_finish;
  logic [15:0] max_latency;
  logic [2:0]  err;
  logic [3:0]  s_acq_count, s_grant_count, s_finish_count;
  logic [4:0]  s_outstanding, s_pending_finish;
  logic [15:0] s_max_latency;
  logic [2:0]  s_err;

  tilelink_txn_monitor u_dut (
    .clk_i(clk), .reset_ni(rst_n),
    .acquire_valid_i(av), .acquire_ready_i(ar),
    .acquire_client_xact_id_i(aid), .acquire_addr_beat_i(abeat),
    .grant_valid_i(gv), .grant_ready_i(gr), .grant_client_xact_id_i(gid),
    .grant_addr_beat_i(gbeat), .grant_has_data_i(ghd), .grant_needs_finish_i(gnf),
    .finish_valid_i(fv), .finish_ready_i(fr),
    .acq_count_o(acq_count), .grant_count_o(grant_count), .finish_count_o(finish_count),
    .outstanding_o(outstanding), .pending_finish_o(pending_finish),
    .max_latency_o(max_latency), .err_o(err)
  );

  tilelink_txn_monitor #(.CNT_W(4)) u_dut_small (
    .clk_i(clk), .reset_ni(rst_n),
    .acquire_valid_i(av), .acquire_ready_i(ar),
    .acquire_client_xact_id_i(aid), .acquire_addr_beat_i(abeat),
    .grant_valid_i(gv), .grant_ready_i(gr), .grant_client_xact_id_i(gid),
    .grant_addr_beat_i(gbeat), .grant_has_data_i(ghd), .grant_needs_finish_i(gnf),
    .finish_valid_i(fv), .finish_ready_i(fr),
    .acq_count_o(s_acq_count), .grant_count_o(s_grant_count), .finish_count_o(s_finish_count),
    .outstanding_o(s_outstanding), .pending_finish_o(s_pending_finish),
    .max_latency_o(s_max_latency), .err_o(s_err)
  );

  typedef struct {
    longint     acq, grant, fin, outst, pend, maxlat;
    logic [2:0] err;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic longint sat(longint v, int w);
    longint m = (64'sd1 <<< w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic chk(string name, logic [63:0] act, longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: which ids are open, when they opened, running totals.
  bit     busy[16];
  bit     in_data[16];
  longint open_cyc[16];
  longint cyc = 0;
  longint m_acq, m_grant, m_fin, m_pend, m_max;
  logic [2:0] m_err;

  function automatic void model_reset();
    foreach (busy[i]) begin busy[i] = 0; in_data[i] = 0; end
    m_acq = 0; m_grant = 0; m_fin = 0; m_pend = 0; m_max = 0; m_err = '0;
  endfunction

  function automatic void model_step();
    exp_t e;
    bit   closes_finish = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (gv && gr) begin
        if (!busy[gid]) m_err[1] = 1'b1;
        else if (in_data[gid] ? (gbeat == Beats - 1) : (!ghd || gbeat == Beats - 1)) begin
          longint lat = cyc - open_cyc[gid];
          busy[gid] = 0; in_data[gid] = 0; m_grant++;
          if (lat > LatMax) lat = LatMax;
          if (lat > m_max) m_max = lat;
          closes_finish = gnf;
        end else if (ghd) in_data[gid] = 1;
      end
      if (av && ar && abeat == 0) begin
        if (busy[aid]) m_err[0] = 1'b1;
        busy[aid] = 1; in_data[aid] = 0; open_cyc[aid] = cyc; m_acq++;
      end
      if (fv && fr) begin
        m_fin++;
        if (!closes_finish) begin
          if (m_pend == 0) m_err[2] = 1'b1;
          else m_pend--;
        end
      end else if (closes_finish) m_pend++;
    end
    e.acq = m_acq; e.grant = m_grant; e.fin = m_fin; e.pend = m_pend; e.maxlat = m_max;
    e.err = m_err; e.outst = 0;
    foreach (busy[i]) e.outst += busy[i];
    exp_q.push_back(e);
    cyc++;
  endfunction

  // Monitor: compare each queued prediction just after the edge that registers it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("acq_count", acq_count, sat(e.acq, 32));
      chk("grant_count", grant_count, sat(e.grant, 32));
      chk("finish_count", finish_count, sat(e.fin, 32));
      chk("outstanding", outstanding, e.outst);
      chk("pending_finish", pending_finish, e.pend);
      chk("max_latency", max_latency, e.maxlat);
      chk("err", err, e.err);
      chk("small_acq_count", s_acq_count, sat(e.acq, 4));
      chk("small_grant_count", s_grant_count, sat(e.grant, 4));
      chk("small_finish_count", s_finish_count, sat(e.fin, 4));
    end
  end

  task automatic clear_in();
    av = 0; ar = 1; gv = 0; gr = 1; fv = 0; fr = 1; ghd = 0; gnf = 0;
    aid = '0; gid = '0; abeat = '0; gbeat = '0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    clear_in();
  endtask

  task automatic do_reset();
    rst_n = 0; step(); rst_n = 1;
  endtask

  task automatic acq(input int id);
    av = 1; aid = 4'(id); abeat = '0; step();
  endtask

  task automatic grant(input int id, input int beat, input bit hd, input bit nf, input bit fin);
    gv = 1; gid = 4'(id); gbeat = 2'(beat); ghd = hd; gnf = nf; fv = fin; step();
  endtask

  initial begin
    clear_in();
    @(negedge clk);
    do_reset();

    // Data grant closes on the last beat; latency counts from the acquire cycle.
    acq(3);
    repeat (4) step();
    for (int b = 0; b < 4; b++) grant(3, b, 1, 0, 0);
    chk("t1_acq_count", acq_count, 1);
    chk("t1_grant_count", grant_count, 1);
    chk("t1_max_latency", max_latency, 8);
    chk("t1_outstanding", outstanding, 0);

    // Full tracker table, then drain in reverse.
    do_reset();
    for (int i = 0; i < 16; i++) acq(i);
    chk("t2_outstanding_full", outstanding, 16);
    chk("t2_err", err, 0);
    for (int i = 15; i >= 0; i--) grant(i, 0, 0, 0, 0);
    chk("t2_outstanding_empty", outstanding, 0);

    // Duplicate acquire, then orphan grant.
    do_reset();
    acq(2);
    acq(2);
    chk("t3_dup_acquire", err, 3'b001);
    grant(7, 0, 0, 0, 0);
    chk("t3_grant_orphan", err, 3'b011);

    // Close-with-finish coinciding with a finish leaves the pending count alone.
    do_reset();
    acq(5);
    acq(6);
    grant(5, 0, 0, 1, 0);
    chk("t4_pending_one", pending_finish, 1);
    grant(6, 0, 0, 1, 1);
    chk("t4_pending_same_cycle", pending_finish, 1);
    fv = 1; step();
    chk("t4_pending_zero", pending_finish, 0);
    fv = 1; step();
    chk("t4_finish_orphan", err, 3'b100);

    // Latency and counter saturation.
    do_reset();
    acq(1);
    repeat ((1 << LatW) + 10) step();
    grant(1, 0, 0, 0, 0);
    chk("t5_max_latency_sat", max_latency, 16'hffff);
    do_reset();
    for (int i = 0; i < 20; i++) acq(i % 16);
    chk("t5_small_acq_sat", s_acq_count, 15);
    chk("t5_acq_count", acq_count, 20);

    // Reset mid-flight drops everything; a late grant is then an orphan.
    do_reset();
    for (int i = 0; i < 5; i++) acq(i);
    do_reset();
    chk("t6_reset_acq", acq_count, 0);
    chk("t6_reset_outstanding", outstanding, 0);
    chk("t6_reset_max", max_latency, 0);
    chk("t6_reset_err", err, 0);
    grant(2, 0, 0, 0, 0);
    chk("t6_orphan_after_reset", err, 3'b010);

    // Random traffic over a few ids so collisions and multi-beat interleaving are frequent.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      av = ($urandom_range(0, 1) == 1); ar = ($urandom_range(0, 3) != 0);
      aid = 4'($urandom_range(0, 3));
      abeat = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      gv = ($urandom_range(0, 1) == 1); gr = ($urandom_range(0, 3) != 0);
      gid = 4'($urandom_range(0, 3)); gbeat = 2'($urandom_range(0, 3));
      ghd = ($urandom_range(0, 1) == 1); gnf = ($urandom_range(0, 1) == 1);
      fv = ($urandom_range(0, 2) == 0); fr = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 799) != 0);
      step();
      rst_n = 1;
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
